// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serial pattern transmitter, MSB first, with repetition count (optional gap: PATTERN_TX_GAP_EN)
module pattern_tx #(
    parameter int              W       = 4,
    parameter logic [W-1:0]    PATTERN = 4'b1010,
    parameter int              CNT_W   = 4,
    parameter int              GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] rep,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done
);

    localparam int IW = $clog2(W);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef PATTERN_TX_GAP_EN
    localparam logic [1:0] GAP   = 2'd2;
    localparam int         GW    = $clog2(GAP_LEN + 1);
`endif
    localparam logic [1:0] DONE  = 2'd3;

    // Parameter sanity: these blocks elaborate only for illegal settings.
    if (W < 2 || W > 16) begin : g_bad_width
    end
    if (GAP_LEN < 1) begin : g_bad_gap_len
    end

    logic [1:0]       state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [CNT_W-1:0] rem, rem_n;
`ifdef PATTERN_TX_GAP_EN
    logic [GW-1:0]    gcnt, gcnt_n;
`endif

    // Next-state, bit index and repetition bookkeeping.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        rem_n   = rem;
`ifdef PATTERN_TX_GAP_EN
        gcnt_n  = gcnt;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    // A request for zero repetitions still sends one pattern.
                    rem_n   = (rep == '0) ? CNT_W'(1) : rep;
                    idx_n   = IW'(W - 1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (idx == '0) begin
                    if (rem > CNT_W'(1)) begin
                        rem_n = rem - CNT_W'(1);
                        idx_n = IW'(W - 1);
`ifdef PATTERN_TX_GAP_EN
                        gcnt_n  = GW'(GAP_LEN - 1);
                        state_n = GAP;
`endif
                    end else begin
                        rem_n   = '0;
                        state_n = DONE;
                    end
                end else begin
                    idx_n = idx - IW'(1);
                end
            end
`ifdef PATTERN_TX_GAP_EN
            GAP: begin
                if (gcnt == '0) begin
                    state_n = SHIFT;
                end else begin
                    gcnt_n = gcnt - GW'(1);
                end
            end
`endif
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transfer on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            rem   <= '0;
`ifdef PATTERN_TX_GAP_EN
            gcnt  <= '0;
`endif
        end else begin
            state <= state_n;
            idx   <= idx_n;
            rem   <= rem_n;
`ifdef PATTERN_TX_GAP_EN
            gcnt  <= gcnt_n;
`endif
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout   <= 1'b0;
            dvalid <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            dout   <= (state_n == SHIFT) && PATTERN[idx_n];
            dvalid <= (state_n == SHIFT);
`ifdef PATTERN_TX_GAP_EN
            busy   <= (state_n == SHIFT) || (state_n == GAP);
`else
            busy   <= (state_n == SHIFT);
`endif
            done   <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - scoreboard bench for pattern_tx
module tb_pattern_tx;

    localparam int           W       = 4;
    localparam logic [W-1:0] PATTERN = 4'b1010;
    localparam int           CNT_W   = 4;
    localparam int           GAP_LEN = 2;
`ifdef PATTERN_TX_GAP_EN
    localparam bit           GAP_ON  = 1'b1;
`else
    localparam bit           GAP_ON  = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] rep;
    logic             dout, dvalid, busy, done;

    pattern_tx #(.W(W), .PATTERN(PATTERN), .CNT_W(CNT_W), .GAP_LEN(GAP_LEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .rep    (rep),
        .dout   (dout),
        .dvalid (dvalid),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected per-cycle {dout, dvalid, busy, done}.
    logic [3:0] q[$];
    bit         mon_en = 1'b0;
    logic [W-1:0] sr = '0;
    int det_cnt = 0;
    int bits    = 0;
    int dones   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push expected outputs: current (idle) cycle, then up to 'limit' transfer cycles.
    task automatic push_exp(input int r, input int limit);
        int reff;
        int n;
        reff = (r == 0) ? 1 : r;
        n = 0;
        q.push_back(4'b0000);
        for (int k = 0; k < reff; k++) begin
            for (int b = W - 1; b >= 0; b--) begin
                if (n < limit) q.push_back({PATTERN[b], 3'b110});
                n++;
            end
            if (GAP_ON && k < reff - 1) begin
                for (int g = 0; g < GAP_LEN; g++) begin
                    if (n < limit) q.push_back(4'b0010);
                    n++;
                end
            end
        end
        if (n < limit) q.push_back(4'b0001);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 500) begin
            step();
            n++;
        end
        chk("drain", q.size(), 0);
        q.delete();
        step();
        step();
    endtask

    task automatic clear_counts();
        det_cnt = 0;
        bits    = 0;
        dones   = 0;
    endtask

    task automatic run(input int r);
        int reff;
        reff = (r == 0) ? 1 : r;
        clear_counts();
        push_exp(r, 1 << 20);
        start = 1'b1;
        rep   = CNT_W'(r);
        step();
        start = 1'b0;
        rep   = '0;
        drain();
        chk("bits", bits, W * reff);
        chk("dones", dones, 1);
        chk("detect", det_cnt, GAP_ON ? reff : 2 * reff - 1);
    endtask

    // Monitor: pop the expectation for this cycle (idle when nothing queued).
    always @(negedge clk) begin
        logic [3:0] e;
        if (mon_en) begin
            e = (q.size() > 0) ? q.pop_front() : 4'b0000;
            chk("outs", {28'd0, dout, dvalid, busy, done}, {28'd0, e});
            sr = {sr[W-2:0], dout};
            if (sr == PATTERN) det_cnt++;
            if (dvalid) bits++;
            if (done) dones++;
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        rep   = '0;
        step();
        mon_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (4) step();

        run(1);
        run(2);
        run(0);
        run(15);
        for (int i = 0; i < 3; i++) run($urandom_range(0, 15));

        // Start held through a rep=3 transfer and its DONE cycle; rep altered mid-way.
        clear_counts();
        push_exp(3, 1 << 20);
        start = 1'b1;
        rep   = 4'd3;
        for (int c = 0; c < 3 * W + (GAP_ON ? 2 * GAP_LEN : 0) + 2; c++) begin
            step();
            if (c == 3) rep = 4'd1;
        end
        start = 1'b0;
        drain();
        chk("held_bits", bits, 3 * W);
        chk("held_dones", dones, 1);

        // Reset in cycle 3 of a rep=2 transfer.
        clear_counts();
        push_exp(2, 3);
        start = 1'b1;
        rep   = 4'd2;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (W * 3) step();
        chk("abort_bits", bits, 3);
        chk("abort_dones", dones, 0);
        chk("abort_drain", q.size(), 0);

        run(1);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
